// File: rtl/mmix_mem_bridge.sv
// MMIX memory port to 32-bit Avalon-MM master bridge.
// Big-endian lane mapping; octa accesses split into two tetra beats.
module mmix_mem_bridge #(
  parameter int ADDR_W = 26
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [63:0]       i_mmix_address,
  input  logic [1:0]        i_mmix_datasize,
  input  logic              i_mmix_read,
  output logic [63:0]       o_mmix_readdata,
  input  logic              i_mmix_write,
  input  logic [63:0]       i_mmix_writedata,
  output logic              o_mmix_done,
  output logic [ADDR_W-1:0] o_avm_address,
  output logic [3:0]        o_avm_byteenable,
  output logic              o_avm_read,
  output logic              o_avm_write,
  output logic [31:0]       o_avm_writedata,
  input  logic [31:0]       i_avm_readdata,
  input  logic              i_avm_readdatavalid,
  input  logic              i_avm_waitrequest
);

  localparam int WA_W = ADDR_W - 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BEAT0 = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_BEAT1 = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_REARM = 3'd6;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_WYDE  = 2'd1;
  localparam logic [1:0] SZ_TETRA = 2'd2;
  localparam logic [1:0] SZ_OCTA  = 2'd3;

  function automatic logic [3:0] f_be(
    input logic [1:0] sz,
    input logic [1:0] lo
  );
    logic [3:0] be;
    unique case (sz)
      SZ_BYTE: be = 4'b1000 >> lo;
      SZ_WYDE: be = lo[1] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate into every lane, then keep only the enabled ones.
  function automatic logic [31:0] f_wlanes(
    input logic [1:0]  sz,
    input logic [3:0]  be,
    input logic [63:0] wd
  );
    logic [31:0] rep;
    logic [31:0] mask;
    unique case (sz)
      SZ_BYTE:  rep = {4{wd[7:0]}};
      SZ_WYDE:  rep = {2{wd[15:0]}};
      SZ_TETRA: rep = wd[31:0];
      default:  rep = wd[63:32];
    endcase
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return rep & mask;
  endfunction

  function automatic logic [31:0] f_extract(
    input logic [1:0]  sz,
    input logic [1:0]  lo,
    input logic [31:0] rd
  );
    logic [31:0] sh;
    logic [31:0] ex;
    sh = rd;
    unique case (sz)
      SZ_BYTE: begin
        sh = rd >> {~lo, 3'b000};
        ex = {24'd0, sh[7:0]};
      end
      SZ_WYDE: begin
        sh = rd >> {~lo[1], 4'b0000};
        ex = {16'd0, sh[15:0]};
      end
      default: ex = sh;
    endcase
    return ex;
  endfunction

  logic [2:0]        r_state;
  logic [1:0]        r_size;
  logic [1:0]        r_lo;
  logic [WA_W-1:0]   r_word;
  logic              r_is_read;
  logic [63:0]       r_wdata;
  logic [63:0]       r_rdata;
  logic              r_done;
  logic [ADDR_W-1:0] r_avm_addr;
  logic [3:0]        r_avm_be;
  logic              r_avm_rd;
  logic              r_avm_wr;
  logic [31:0]       r_avm_wd;

  logic              w_req;
  logic [WA_W-1:0]   w_cap_word;
  logic [1:0]        w_cap_lo;
  logic [3:0]        w_cap_be;
  logic [31:0]       w_cap_wd;
  logic [31:0]       w_lane_rd;
  logic              w_is_octa;
  logic              w_more;
  logic              w_unused;

  assign w_req = i_mmix_read | i_mmix_write;

  always_comb begin
    w_cap_word = i_mmix_address[ADDR_W-1:2];
    if (i_mmix_datasize == SZ_OCTA) w_cap_word[0] = 1'b0;
  end

  always_comb begin
    w_cap_lo = 2'b00;
    unique case (i_mmix_datasize)
      SZ_BYTE: w_cap_lo = i_mmix_address[1:0];
      SZ_WYDE: w_cap_lo = {i_mmix_address[1], 1'b0};
      default: w_cap_lo = 2'b00;
    endcase
  end

  assign w_cap_be  = f_be(i_mmix_datasize, w_cap_lo);
  assign w_cap_wd  = f_wlanes(i_mmix_datasize, w_cap_be, i_mmix_writedata);
  assign w_lane_rd = f_extract(r_size, r_lo, i_avm_readdata);
  assign w_is_octa = (r_size == SZ_OCTA);
  assign w_more    = w_is_octa &&
                     (r_state == S_BEAT0 || r_state == S_WAIT0);
  assign w_unused  = &{1'b0, i_mmix_address[63:ADDR_W]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_size     <= SZ_BYTE;
      r_lo       <= 2'b00;
      r_word     <= '0;
      r_is_read  <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_done     <= 1'b0;
      r_avm_addr <= '0;
      r_avm_be   <= 4'b0000;
      r_avm_rd   <= 1'b0;
      r_avm_wr   <= 1'b0;
      r_avm_wd   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_size     <= i_mmix_datasize;
            r_lo       <= w_cap_lo;
            r_word     <= w_cap_word;
            r_is_read  <= i_mmix_read;
            r_wdata    <= i_mmix_writedata;
            r_avm_addr <= {w_cap_word, 2'b00};
            r_avm_be   <= w_cap_be;
            r_avm_rd   <= i_mmix_read;
            r_avm_wr   <= ~i_mmix_read;
            r_avm_wd   <= i_mmix_read ? 32'd0 : w_cap_wd;
            if (i_mmix_read) r_rdata <= '0;
            r_state    <= S_BEAT0;
          end
        end
        S_BEAT0, S_BEAT1: begin
          if (!i_avm_waitrequest) begin
            r_avm_rd <= 1'b0;
            r_avm_wr <= 1'b0;
            if (r_is_read) begin
              r_state <= (r_state == S_BEAT0) ? S_WAIT0 : S_WAIT1;
            end else if (w_more) begin
              r_avm_addr <= {r_word[WA_W-1:1], 1'b1, 2'b00};
              r_avm_wr   <= 1'b1;
              r_avm_wd   <= r_wdata[31:0];
              r_state    <= S_BEAT1;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_WAIT0, S_WAIT1: begin
          if (i_avm_readdatavalid) begin
            if (!w_is_octa) r_rdata[31:0] <= w_lane_rd;
            else if (r_state == S_WAIT0) r_rdata[63:32] <= i_avm_readdata;
            else r_rdata[31:0] <= i_avm_readdata;
            if (w_more) begin
              r_avm_addr <= {r_word[WA_W-1:1], 1'b1, 2'b00};
              r_avm_rd   <= 1'b1;
              r_state    <= S_BEAT1;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_REARM;
        // A request still held after done must not be taken again.
        S_REARM: if (!w_req) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mmix_readdata  = r_rdata;
  assign o_mmix_done      = r_done;
  assign o_avm_address    = r_avm_addr;
  assign o_avm_byteenable = r_avm_be;
  assign o_avm_read       = r_avm_rd;
  assign o_avm_write      = r_avm_wr;
  assign o_avm_writedata  = r_avm_wd;

endmodule

// File: tb/tb_mmix_mem_bridge.sv
// Bench for mmix_mem_bridge: Avalon slave with byte memory,
// directed scenarios and a randomized byte-level reference model.
module tb_mmix_mem_bridge;
  localparam int ADDR_W = 26;

  logic              clk = 1'b0;
  logic              i_reset;
  logic [63:0]       i_mmix_address;
  logic [1:0]        i_mmix_datasize;
  logic              i_mmix_read;
  logic [63:0]       o_mmix_readdata;
  logic              i_mmix_write;
  logic [63:0]       i_mmix_writedata;
  logic              o_mmix_done;
  logic [ADDR_W-1:0] o_avm_address;
  logic [3:0]        o_avm_byteenable;
  logic              o_avm_read;
  logic              o_avm_write;
  logic [31:0]       o_avm_writedata;
  logic [31:0]       i_avm_readdata;
  logic              i_avm_readdatavalid;
  logic              i_avm_waitrequest;

  always #5 clk = ~clk;

  mmix_mem_bridge #(.ADDR_W(ADDR_W)) dut (
    .i_clk              (clk),
    .i_reset            (i_reset),
    .i_mmix_address     (i_mmix_address),
    .i_mmix_datasize    (i_mmix_datasize),
    .i_mmix_read        (i_mmix_read),
    .o_mmix_readdata    (o_mmix_readdata),
    .i_mmix_write       (i_mmix_write),
    .i_mmix_writedata   (i_mmix_writedata),
    .o_mmix_done        (o_mmix_done),
    .o_avm_address      (o_avm_address),
    .o_avm_byteenable   (o_avm_byteenable),
    .o_avm_read         (o_avm_read),
    .o_avm_write        (o_avm_write),
    .o_avm_writedata    (o_avm_writedata),
    .i_avm_readdata     (i_avm_readdata),
    .i_avm_readdatavalid(i_avm_readdatavalid),
    .i_avm_waitrequest  (i_avm_waitrequest)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic              rd;
  } beat_t;

  beat_t log_q[$];
  beat_t cur;

  logic [7:0] smem [int unsigned];
  logic [7:0] rmem [int unsigned];

  int          cfg_stall = 0;
  int          cfg_lat   = 1;
  bit          cfg_rand  = 0;
  bit          cfg_noisy = 0;
  int          stall_left = 0;
  int          pend_cnt   = 0;
  logic [31:0] pend_data  = '0;
  bit          in_cmd     = 0;

  function automatic logic [7:0] init_b(input int unsigned a);
    return 8'((a ^ (a >> 8) ^ 32'h5A) & 32'hFF);
  endfunction

  function automatic logic [7:0] s_byte(input int unsigned a);
    if (smem.exists(a)) return smem[a];
    return init_b(a);
  endfunction

  function automatic logic [7:0] r_byte(input int unsigned a);
    if (rmem.exists(a)) return rmem[a];
    return init_b(a);
  endfunction

  // Reference: big-endian bytes, address aligned down to the size.
  function automatic logic [63:0] ref_read(
    input logic [63:0] addr, input logic [1:0] sz);
    int n;
    int unsigned a;
    logic [63:0] v;
    n = 1 << sz;
    a = 32'(addr[ADDR_W-1:0]);
    a = a - (a % 32'(n));
    v = '0;
    for (int k = 0; k < n; k++) v = (v << 8) | 64'(r_byte(a + 32'(k)));
    return v;
  endfunction

  function automatic void ref_write(
    input logic [63:0] addr, input logic [1:0] sz, input logic [63:0] wd);
    int n;
    int unsigned a;
    n = 1 << sz;
    a = 32'(addr[ADDR_W-1:0]);
    a = a - (a % 32'(n));
    for (int k = 0; k < n; k++) rmem[a + 32'(k)] = wd[8*(n-1-k) +: 8];
  endfunction

  // Avalon slave, driven on the falling edge.
  always @(negedge clk) begin
    int unsigned a;
    if (pend_cnt > 0) begin
      pend_cnt--;
      i_avm_readdatavalid = (pend_cnt == 0);
      i_avm_readdata = (pend_cnt == 0) ? pend_data : $urandom;
    end else begin
      i_avm_readdatavalid = cfg_noisy && ($urandom_range(0, 7) == 0);
      i_avm_readdata = $urandom;
    end
    if (o_avm_read || o_avm_write) begin
      if (!in_cmd) begin
        in_cmd = 1;
        cur = '{addr: o_avm_address, be: o_avm_byteenable,
                wd: o_avm_writedata, rd: o_avm_read};
        stall_left = cfg_rand ? $urandom_range(0, 3) : cfg_stall;
        n_vec++;
        if (o_avm_read && o_avm_write) begin
          n_err++;
          $display("FAIL cmd_excl: read=%b write=%b required not both",
                   o_avm_read, o_avm_write);
        end
      end else begin
        n_vec++;
        if (o_avm_address !== cur.addr || o_avm_byteenable !== cur.be ||
            o_avm_read !== cur.rd ||
            (!cur.rd && o_avm_writedata !== cur.wd)) begin
          n_err++;
          $display("FAIL cmd_stable: got a=%h be=%b wd=%h rd=%b required a=%h be=%b wd=%h rd=%b",
                   o_avm_address, o_avm_byteenable, o_avm_writedata,
                   o_avm_read, cur.addr, cur.be, cur.wd, cur.rd);
        end
      end
      if (stall_left > 0) begin
        i_avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        i_avm_waitrequest = 1'b0;
        in_cmd = 0;
        log_q.push_back(cur);
        a = 32'(cur.addr);
        if (cur.rd) begin
          n_vec++;
          if (pend_cnt != 0) begin
            n_err++;
            $display("FAIL one_outstanding: pending=%0d required 0", pend_cnt);
          end
          pend_data = {s_byte(a), s_byte(a + 1), s_byte(a + 2), s_byte(a + 3)};
          pend_cnt = cfg_rand ? $urandom_range(1, 3) : cfg_lat;
        end else begin
          for (int j = 0; j < 4; j++)
            if (cur.be[j]) smem[a + 32'(3 - j)] = cur.wd[8*j +: 8];
        end
      end
    end else begin
      in_cmd = 0;
      i_avm_waitrequest = cfg_noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic run_req(
    input  logic        rd,
    input  logic        both,
    input  logic [1:0]  sz,
    input  logic [63:0] addr,
    input  logic [63:0] wd,
    input  int          hold,
    output logic [63:0] rdata,
    output int          lat,
    output logic        ok,
    output int          pulses);
    int c;
    @(negedge clk);
    i_mmix_address   = addr;
    i_mmix_datasize  = sz;
    i_mmix_writedata = wd;
    i_mmix_read      = rd;
    i_mmix_write     = !rd || both;
    ok = 0;
    c = 0;
    while (c < 200 && !ok) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        i_mmix_address   = {$urandom, $urandom};
        i_mmix_datasize  = 2'($urandom_range(0, 3));
        i_mmix_writedata = {$urandom, $urandom};
      end
      if (o_mmix_done) ok = 1;
    end
    lat = c;
    rdata = o_mmix_readdata;
    pulses = ok ? 1 : 0;
    repeat (hold) begin
      @(negedge clk);
      if (o_mmix_done) pulses++;
    end
    i_mmix_read  = 1'b0;
    i_mmix_write = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (o_mmix_done) pulses++;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (o_mmix_done !== 1'b0) begin
      n_err++; $display("FAIL reset_done: got %b required 0", o_mmix_done);
    end
    n_vec++;
    if (o_mmix_readdata !== 64'd0) begin
      n_err++; $display("FAIL reset_rdata: got %h required 0", o_mmix_readdata);
    end
    n_vec++;
    if (o_avm_read !== 1'b0 || o_avm_write !== 1'b0) begin
      n_err++; $display("FAIL reset_cmd: got r=%b w=%b required 0 0", o_avm_read, o_avm_write);
    end
    n_vec++;
    if (o_avm_address !== '0 || o_avm_byteenable !== 4'b0 || o_avm_writedata !== 32'd0) begin
      n_err++;
      $display("FAIL reset_bus: got a=%h be=%b wd=%h required 0 0 0",
               o_avm_address, o_avm_byteenable, o_avm_writedata);
    end
    i_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_byte_read();
    logic [63:0] rdv; int lat; logic ok; int pulses; int base;
    smem[0] = 8'h11; smem[1] = 8'h22; smem[2] = 8'h33; smem[3] = 8'h44;
    base = log_q.size();
    run_req(1'b1, 1'b0, 2'd0, 64'hABCD_0000_0000_0001, 64'd0, 2, rdv, lat, ok, pulses);
    n_vec++;
    if (!ok || rdv !== 64'h22) begin
      n_err++; $display("FAIL byte_rdata: got %h ok=%b required 22", rdv, ok);
    end
    n_vec++;
    if (lat !== 3) begin
      n_err++; $display("FAIL byte_latency: got %0d required 3", lat);
    end
    n_vec++;
    if (pulses !== 1) begin
      n_err++; $display("FAIL byte_pulse: got %0d pulses required 1", pulses);
    end
    n_vec++;
    if (log_q.size() != base + 1 || log_q[base].addr !== 26'h0 ||
        log_q[base].be !== 4'b0100 || log_q[base].rd !== 1'b1) begin
      n_err++;
      $display("FAIL byte_bus: got %0d beats required 1 read at 0 be 0100",
               log_q.size() - base);
    end
  endtask

  task automatic test_wyde_write();
    logic [63:0] rdv; int lat; logic ok; int pulses; int base;
    base = log_q.size();
    run_req(1'b0, 1'b0, 2'd1, 64'h0000_0000_0000_0006,
            64'hFFFF_FFFF_FFFF_BEEF, 3, rdv, lat, ok, pulses);
    n_vec++;
    if (!ok || lat !== 2 || pulses !== 1) begin
      n_err++;
      $display("FAIL wyde_done: got ok=%b lat=%0d pulses=%0d required 1 2 1", ok, lat, pulses);
    end
    n_vec++;
    if (log_q.size() != base + 1) begin
      n_err++; $display("FAIL wyde_count: got %0d writes required 1", log_q.size() - base);
    end else begin
      n_vec++;
      if (log_q[base].addr !== 26'h4 || log_q[base].be !== 4'b0011 ||
          log_q[base].wd !== 32'h0000_BEEF || log_q[base].rd !== 1'b0) begin
        n_err++;
        $display("FAIL wyde_bus: got a=%h be=%b wd=%h required 4 0011 0000beef",
                 log_q[base].addr, log_q[base].be, log_q[base].wd);
      end
    end
    n_vec++;
    if (s_byte(6) !== 8'hBE || s_byte(7) !== 8'hEF) begin
      n_err++; $display("FAIL wyde_mem: got %h%h required beef", s_byte(6), s_byte(7));
    end
  endtask

  task automatic test_octa_read();
    logic [63:0] rdv; int lat; logic ok; int pulses; int base;
    smem[32'h10008] = 8'hDE; smem[32'h10009] = 8'hAD;
    smem[32'h1000A] = 8'hBE; smem[32'h1000B] = 8'hEF;
    smem[32'h1000C] = 8'h01; smem[32'h1000D] = 8'h23;
    smem[32'h1000E] = 8'h45; smem[32'h1000F] = 8'h67;
    base = log_q.size();
    run_req(1'b1, 1'b0, 2'd3, 64'h0000_0000_0001_000F, 64'd0, 0, rdv, lat, ok, pulses);
    n_vec++;
    if (!ok || rdv !== 64'hDEAD_BEEF_0123_4567) begin
      n_err++; $display("FAIL octa_rdata: got %h required deadbeef01234567", rdv);
    end
    n_vec++;
    if (lat !== 5 || pulses !== 1) begin
      n_err++; $display("FAIL octa_timing: got lat=%0d pulses=%0d required 5 1", lat, pulses);
    end
    n_vec++;
    if (log_q.size() != base + 2 || log_q[base].addr !== 26'h10008 ||
        log_q[base + 1].addr !== 26'h1000C || log_q[base].be !== 4'hF ||
        log_q[base + 1].be !== 4'hF) begin
      n_err++;
      $display("FAIL octa_bus: got %0d beats required reads at 10008 then 1000c",
               log_q.size() - base);
    end
  endtask

  task automatic test_octa_write();
    logic [63:0] rdv; int lat; logic ok; int pulses; int base;
    base = log_q.size();
    run_req(1'b0, 1'b0, 2'd3, 64'h0000_0000_0002_0005,
            64'h0102_0304_0506_0708, 0, rdv, lat, ok, pulses);
    n_vec++;
    if (!ok || lat !== 3 || pulses !== 1) begin
      n_err++;
      $display("FAIL octaw_done: got ok=%b lat=%0d pulses=%0d required 1 3 1", ok, lat, pulses);
    end
    n_vec++;
    if (log_q.size() != base + 2 ||
        log_q[base].addr !== 26'h20000 || log_q[base].wd !== 32'h0102_0304 ||
        log_q[base + 1].addr !== 26'h20004 || log_q[base + 1].wd !== 32'h0506_0708) begin
      n_err++;
      $display("FAIL octaw_bus: got %0d beats required 20000:01020304 20004:05060708",
               log_q.size() - base);
    end
  endtask

  task automatic test_waitrequest_stall();
    logic [63:0] rdv; int lat; logic ok; int pulses; int base;
    base = log_q.size();
    cfg_stall = 4;
    run_req(1'b0, 1'b0, 2'd2, 64'h0000_0000_0003_0002,
            64'h1111_2222_CAFE_F00D, 0, rdv, lat, ok, pulses);
    cfg_stall = 0;
    n_vec++;
    if (!ok || lat !== 6 || pulses !== 1) begin
      n_err++;
      $display("FAIL stall_done: got ok=%b lat=%0d pulses=%0d required 1 6 1", ok, lat, pulses);
    end
    n_vec++;
    if (o_avm_write !== 1'b0) begin
      n_err++; $display("FAIL stall_drop: got write=%b required 0", o_avm_write);
    end
    n_vec++;
    if (log_q.size() != base + 1 || log_q[base].addr !== 26'h30000 ||
        log_q[base].be !== 4'hF || log_q[base].wd !== 32'hCAFE_F00D) begin
      n_err++;
      $display("FAIL stall_bus: got %0d beats required one write 30000 f cafef00d",
               log_q.size() - base);
    end
  endtask

  task automatic test_reset_mid_octa();
    logic [63:0] rdv; int lat; logic ok; int pulses; int base; int c;
    cfg_lat = 6;
    base = log_q.size();
    @(negedge clk);
    i_mmix_address = 64'h0000_0000_0004_0000;
    i_mmix_datasize = 2'd3;
    i_mmix_read = 1'b1;
    i_mmix_write = 1'b0;
    c = 0;
    while (log_q.size() < base + 2 && c < 100) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (log_q.size() < base + 2) begin
      n_err++; $display("FAIL rst_reach_beat1: got %0d beats required 2", log_q.size() - base);
    end
    @(negedge clk);
    i_reset = 1'b1;
    i_mmix_read = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_avm_read !== 1'b0 || o_avm_write !== 1'b0 || o_avm_address !== '0 ||
        o_avm_byteenable !== 4'b0 || o_avm_writedata !== 32'd0) begin
      n_err++;
      $display("FAIL rst_mid_bus: got r=%b w=%b a=%h be=%b required all 0",
               o_avm_read, o_avm_write, o_avm_address, o_avm_byteenable);
    end
    n_vec++;
    if (o_mmix_done !== 1'b0 || o_mmix_readdata !== 64'd0) begin
      n_err++;
      $display("FAIL rst_mid_mmix: got done=%b rdata=%h required 0 0", o_mmix_done, o_mmix_readdata);
    end
    i_reset = 1'b0;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_mmix_done) pulses++;
    end
    n_vec++;
    if (pulses != 0 || o_mmix_readdata !== 64'd0) begin
      n_err++;
      $display("FAIL rst_late_valid: got pulses=%0d rdata=%h required 0 0", pulses, o_mmix_readdata);
    end
    cfg_lat = 1;
    run_req(1'b1, 1'b0, 2'd2, 64'h0000_0000_0001_0008, 64'd0, 0, rdv, lat, ok, pulses);
    n_vec++;
    if (!ok || rdv !== 64'hDEAD_BEEF || lat !== 3 || pulses !== 1) begin
      n_err++;
      $display("FAIL rst_recover: got rdata=%h lat=%0d pulses=%0d required deadbeef 3 1",
               rdv, lat, pulses);
    end
  endtask

  task automatic test_random();
    logic [63:0] rdv; int lat; logic ok; int pulses; int base;
    logic rd; logic both; logic [1:0] sz; logic [63:0] addr; logic [63:0] wd;
    logic [63:0] exp_v; int hold;
    cfg_rand = 1;
    cfg_noisy = 1;
    for (int it = 0; it < 300; it++) begin
      rd   = 1'($urandom_range(0, 1));
      both = rd && ($urandom_range(0, 7) == 0);
      sz   = 2'($urandom_range(0, 3));
      addr = {$urandom, $urandom};
      addr[ADDR_W-1:0] = 26'h50000 + 26'($urandom_range(0, 63));
      wd   = {$urandom, $urandom};
      hold = $urandom_range(0, 2);
      exp_v = ref_read(addr, sz);
      base = log_q.size();
      run_req(rd, both, sz, addr, wd, hold, rdv, lat, ok, pulses);
      n_vec++;
      if (!ok || pulses != 1) begin
        n_err++;
        $display("FAIL rand_done[%0d]: got ok=%b pulses=%0d required 1 1", it, ok, pulses);
      end
      n_vec++;
      if (log_q.size() - base != ((sz == 2'd3) ? 2 : 1)) begin
        n_err++;
        $display("FAIL rand_beats[%0d]: got %0d required %0d", it,
                 log_q.size() - base, (sz == 2'd3) ? 2 : 1);
      end
      if (rd) begin
        n_vec++;
        if (rdv !== exp_v) begin
          n_err++;
          $display("FAIL rand_rdata[%0d]: sz=%0d a=%h got %h required %h",
                   it, sz, addr[ADDR_W-1:0], rdv, exp_v);
        end
      end else begin
        ref_write(addr, sz, wd);
      end
    end
    cfg_rand = 0;
    cfg_noisy = 0;
  endtask

  initial begin
    i_reset = 1'b1;
    i_mmix_address = '0;
    i_mmix_datasize = 2'd0;
    i_mmix_read = 1'b0;
    i_mmix_write = 1'b0;
    i_mmix_writedata = '0;
    i_avm_readdata = '0;
    i_avm_readdatavalid = 1'b0;
    i_avm_waitrequest = 1'b0;
    test_reset();
    test_byte_read();
    test_wyde_write();
    test_octa_read();
    test_octa_write();
    test_waitrequest_stall();
    test_reset_mid_octa();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mmix_mem_bridge.md
Name: mmix_mem_bridge

Overview:
- Downstream of the MMIX `cpu` core's memory port.
- Accepts one MMIX request at a time: byte, wyde, tetra or octa; read or write; 64-bit address; big-endian.
- Executes it as one or two single-word transfers on a 32-bit Avalon-MM master to on-board SDRAM/SRAM.
- Returns right-justified read data and a one-cycle `mmix_done` pulse.

Parameters:
ADDR_W, 26, width of avm_address (byte address); mmix_address[ADDR_W-1:0] used, upper bits ignored

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
mmix_address  in  64  MMIX byte address
mmix_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
mmix_read  in  1  read request, level, held until done
mmix_readdata  out  64  read result, right-justified, zero-extended
mmix_write  in  1  write request, level, held until done
mmix_writedata  in  64  write data, right-justified (low bits used)
mmix_done  out  1  one-cycle completion pulse
avm_address  out  ADDR_W  word-aligned byte address (bits [1:0]=0)
avm_byteenable  out  4  lane enables
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  32  Avalon write data
avm_readdata  in  32  Avalon read data
avm_readdatavalid  in  1  read data valid
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset values:
  - mmix_done=0, mmix_readdata=0.
  - avm_read=0, avm_write=0, avm_address=0, avm_byteenable=0, avm_writedata=0.
  - State IDLE.
  - Reset mid-transfer drops avm_read/avm_write the next edge and discards any outstanding data.
- Alignment: the address is aligned down to the access size, as in MMIX (ignore bit 0 for wyde, [1:0] for tetra, [2:0] for octa).
- Endianness: byte offset o=addr[1:0] maps to lane 3-o, i.e. data bits [8*(3-o)+7 : 8*(3-o)].
  - byte: be=1<<(3-o).
  - wyde: be=1100 if addr[1]=0, 0011 if addr[1]=1.
  - tetra: be=1111.
  - octa: two beats, high tetra at addr&~7, then low tetra at (addr&~7)+4, both be=1111.
- Write data placement: the bridge replicates data into the selected lanes; unselected lanes are don't-care (drive 0).
- States: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, DONE, REARM.
- IDLE:
  - On mmix_read|mmix_write, capture address, size, direction and writedata. Read wins if both are high.
  - Go to BEAT0. avm_read or avm_write goes high at the next edge.
- BEATn:
  - Hold avm_* command stable while avm_waitrequest=1.
  - On an edge with waitrequest=0, drop the command.
  - Write: beat complete. Read: go to WAITn.
- WAITn (read only):
  - Wait for avm_readdatavalid.
  - Extract the selected lanes right-justified: byte→[7:0], wyde→[15:0], tetra→[31:0], octa beat0→[63:32], beat1→[31:0].
  - Zero all other bits of mmix_readdata at the start of the request.
- Beat sequencing: after beat0 of an octa go to BEAT1; otherwise go to DONE.
- DONE: mmix_done=1 for exactly one cycle; mmix_readdata is final and held stable until the next captured read.
- REARM:
  - Wait until mmix_read=0 and mmix_write=0, then return to IDLE.
  - This prevents a still-high request from being recaptured.
- Outstanding transfers: only one at a time; readdatavalid outside WAITn is ignored.
- Minimum latency, waitrequest=0, readdatavalid one cycle after accept:
  - Request sampled at edge E0, avm_read high E0..E1, readdatavalid at E2, done high E2..E3.
  - Byte/wyde/tetra read: 3 cycles.
  - Write: 2 cycles.
  - Octa read: 5 cycles; octa write: 3 cycles.
- mmix_datasize and address changing after capture are ignored.

Test Plan:
- Byte read, addr=0x...0001, memory word at 0 = 0x11223344, no stalls → avm_address=0, be=0100, mmix_readdata=0x22, done 3 cycles after request, single pulse.
- Wyde write, addr=0x06, data=0xBEEF → one avm_write, address=0x04, be=0011, writedata[15:0]=0xBEEF; done pulse; no second write while mmix_write still held.
- Octa read, addr=0x1000F (aligned to 0x10008), words 0x10008=0xDEADBEEF and 0x1000C=0x01234567 → two reads in order 0x10008 then 0x1000C, mmix_readdata=0xDEADBEEF01234567.
- avm_waitrequest high 4 cycles on a tetra write → address, be=1111 and data held stable all 4 cycles; avm_write drops the edge after waitrequest falls; done 4 cycles later than the no-stall case.
- Reset asserted while in WAIT1 of an octa read → next edge all outputs at reset values, no done pulse; a late readdatavalid is ignored; the next read completes normally.
